// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/ready port between fetch unit and memory
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem request, IF/ID register with one-entry skid
module if_fetch_unit (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_freeze,
    input  logic                   i_branch_taken,
    input  logic [31:0]            i_branch_addr,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            o_instruction,
    output logic [31:0]            o_pc,
    output logic                   o_valid
);
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;
    logic [31:0] r_pend_target;

    logic        w_req;
    logic        w_arrive;
    logic        w_wait;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_arrive   = w_req & imem.imem_ready;
    assign w_wait     = w_req & ~imem.imem_ready;
    assign w_target   = i_branch_addr & ~32'h3;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A redirect that lands on an outstanding request must let that request finish first.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (i_branch_taken && w_wait) w_state_next = S_DRAIN;
            S_DRAIN: if (imem.imem_ready)          w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        w_req = 1'b1;
        case (r_state)
            S_RUN:   w_req = ~r_skid_valid;
            S_DRAIN: w_req = 1'b1;
            default: w_req = 1'b1;
        endcase
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= 32'd0;
            r_out_instr   <= BUBBLE;
            r_out_pc      <= 32'd0;
            r_out_valid   <= 1'b0;
            r_skid_instr  <= BUBBLE;
            r_skid_pc     <= 32'd0;
            r_skid_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (r_state == S_DRAIN) begin
            // The word returning here belongs to the flushed path and is dropped.
            if (i_branch_taken) begin
                r_pend_target <= w_target;
            end
            if (imem.imem_ready) begin
                r_pc <= i_branch_taken ? w_target : r_pend_target;
            end
        end else if (i_branch_taken) begin
            r_out_instr  <= BUBBLE;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            if (w_wait) begin
                r_pend_target <= w_target;
            end else begin
                r_pc <= w_target;
            end
        end else if (w_arrive) begin
            r_pc <= w_pc_plus4;
            if (i_freeze) begin
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc    <= w_pc_plus4;
                r_skid_valid <= 1'b1;
            end else begin
                r_out_instr <= imem.imem_rdata;
                r_out_pc    <= w_pc_plus4;
                r_out_valid <= 1'b1;
            end
        end else if (!i_freeze) begin
            if (r_skid_valid) begin
                r_out_instr  <= r_skid_instr;
                r_out_pc     <= r_skid_pc;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_instr <= BUBBLE;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_instruction = r_out_instr;
    assign o_pc          = r_out_pc;
    assign o_valid       = r_out_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with wait-state memory and queue-based model
module tb_if_fetch_unit;
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_valid;

    if_fetch_unit_if bus();

    if_fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_freeze       (freeze),
        .i_branch_taken (branch_taken),
        .i_branch_addr  (branch_addr),
        .imem           (bus),
        .o_instruction  (o_instruction),
        .o_pc           (o_pc),
        .o_valid        (o_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int waits = 0;
    int cnt = 0;
    bit prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    // Model: fetched words not yet handed to decode sit in a queue; a redirect
    // that arrives while a request is outstanding is remembered until it completes.
    logic [31:0] m_pc;
    word_t       m_out;
    bit          m_valid;
    word_t       m_held[$];
    bit          m_pending;
    logic [31:0] m_tgt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_req();
        return m_pending || (m_held.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc      = 32'd0;
        m_out     = '{instr: BUBBLE, pc: 32'd0};
        m_valid   = 1'b0;
        m_held.delete();
        m_pending = 1'b0;
        m_tgt     = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = 32'd0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        cnt = 0;
        prev_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input bit f, input bit b, input logic [31:0] ba);
        bit    rq;
        bit    rdy;
        word_t w;
        freeze = f;
        branch_taken = b;
        branch_addr = ba;
        check("instruction", o_instruction, m_out.instr);
        check("pc", o_pc, m_out.pc);
        check("valid", 32'(o_valid), 32'(m_valid));
        check("imem_req", 32'(bus.imem_req), 32'(m_req()));
        check("imem_addr", bus.imem_addr, m_pc);
        if (prev_wait) begin
            check("req_held", 32'(bus.imem_req), 32'd1);
            check("addr_held", bus.imem_addr, prev_addr);
        end
        if (!bus.imem_req) begin
            rdy = 1'b0;
            cnt = 0;
        end else begin
            rdy = (cnt >= waits);
            cnt = rdy ? 0 : cnt + 1;
        end
        bus.imem_ready = rdy;
        bus.imem_rdata = bus.imem_addr;
        prev_wait = bus.imem_req && !rdy;
        prev_addr = bus.imem_addr;

        rq = m_req();
        if (b) begin
            m_out.instr = BUBBLE;
            m_valid = 1'b0;
            m_held.delete();
            if (rq && !rdy) begin
                m_pending = 1'b1;
                m_tgt = ba & ~32'h3;
            end else begin
                m_pending = 1'b0;
                m_pc = ba & ~32'h3;
            end
        end else if (m_pending) begin
            if (rdy) begin
                m_pending = 1'b0;
                m_pc = m_tgt;
            end
        end else if (rq && rdy) begin
            w.instr = m_pc;
            w.pc = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            if (f) begin
                m_held.push_back(w);
            end else begin
                m_out = w;
                m_valid = 1'b1;
            end
        end else if (!f) begin
            if (m_held.size() > 0) begin
                m_out = m_held.pop_front();
                m_valid = 1'b1;
            end else begin
                m_out.instr = BUBBLE;
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_literals();
        check("rst_instr", o_instruction, BUBBLE);
        check("rst_pc", o_pc, 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd1);
        check("rst_addr", bus.imem_addr, 32'd0);
    endtask

    initial begin
        do_reset();
        reset_literals();

        waits = 0;
        cycle(0, 0, 0);
        check("zw_first_instr", o_instruction, 32'd0);
        check("zw_first_valid", 32'(o_valid), 32'd1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("zw_third_instr", o_instruction, 32'd8);
        check("zw_third_pc", o_pc, 32'd12);

        waits = 2;
        for (int i = 0; i < 7; i++) cycle(0, 0, 0);

        waits = 0;
        cycle(1, 0, 0);
        check("skid_req_low", 32'(bus.imem_req), 32'd0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("skid_release_valid", 32'(o_valid), 32'd1);
        cycle(0, 0, 0);

        cycle(0, 1, 32'h100);
        check("br_bubble_valid", 32'(o_valid), 32'd0);
        check("br_addr", bus.imem_addr, 32'h100);
        cycle(0, 0, 0);
        check("br_target_instr", o_instruction, 32'h100);
        check("br_target_pc", o_pc, 32'h104);

        waits = 3;
        cycle(0, 0, 0);
        cycle(0, 1, 32'h203);
        check("drain_addr_held", bus.imem_addr, 32'h104);
        check("drain_valid", 32'(o_valid), 32'd0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("drain_new_addr", bus.imem_addr, 32'h200);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h500);
        cycle(0, 1, 32'h300);
        cycle(0, 0, 0);
        check("drain_second_addr", bus.imem_addr, 32'h300);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        check("drain_target_instr", o_instruction, 32'h300);
        check("drain_target_pc", o_pc, 32'h304);

        waits = 0;
        cycle(1, 0, 0);
        cycle(1, 1, 32'hFFFF_FFF8);
        check("frzbr_valid", 32'(o_valid), 32'd0);
        check("frzbr_req", 32'(bus.imem_req), 32'd1);
        check("frzbr_addr", bus.imem_addr, 32'hFFFF_FFF8);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("wrap_instr", o_instruction, 32'hFFFF_FFFC);
        check("wrap_pc", o_pc, 32'd0);
        check("wrap_addr", bus.imem_addr, 32'd0);
        cycle(0, 0, 0);

        waits = 2;
        cycle(0, 0, 0);
        do_reset();
        reset_literals();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        check("post_rst_instr", o_instruction, 32'd0);
        check("post_rst_pc", o_pc, 32'd4);
        cycle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the 5-stage ARM pipeline; it produces the `instruction`/`pc` pair consumed by the decode stage. It owns the program counter and drives a req/ready instruction-memory port that may insert wait states. It includes the IF/ID pipeline register with a one-entry skid buffer, so decode-stage freezes never drop a fetched word. Taken branches from execute redirect fetch and flush it.

## Interface
- No parameters; data width 32, bubble word 32'hF000_0000 (cond NV, so the decode stage zeroes all controls).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall from decode; IF/ID register holds
- branch_taken  in  1  one-cycle redirect/flush from execute
- branch_addr  in  32  redirect target; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  request completes this cycle; zero-wait allowed
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
- instruction  out  32  IF/ID instruction to decode
- pc  out  32  IF/ID fetch address + 4 (BL link value)
- valid  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - pc_reg: next fetch address
  - out_{instr,pc,valid}: IF/ID register
  - skid_{instr,pc,valid}
  - pend_target
  - state ∈ {RUN, DRAIN}
- imem_addr = pc_reg always. imem_req = 1 in DRAIN; in RUN, imem_req = !skid_valid.
- Memory protocol: once imem_req rises, imem_req and imem_addr stay stable until imem_ready. Only the block's own logic may end a request.
- RUN, word arrival (req & ready) with no branch:
  - pc_reg += 4 (mod 2^32; wraps FFFF_FFFC → 0).
  - !freeze: out ← {rdata, pc_reg+4, 1}.
  - freeze: skid ← {rdata, pc_reg+4, 1}; out holds.
- RUN, no arrival, !freeze:
  - skid_valid: out ← skid, skid_valid ← 0.
  - otherwise: out ← bubble (F000_0000, pc held, valid 0).
- freeze with no arrival: out and skid hold.
- branch_taken has priority over everything, including freeze:
  - out ← bubble, skid_valid ← 0; any arriving word is discarded.
  - If no request is pending past this cycle (req low, or req & ready): pc_reg ← branch_addr & ~3, state stays RUN.
  - If req & !ready: pend_target ← branch_addr & ~3, state ← DRAIN.
- DRAIN: request held at the old address; the returning word is discarded.
  - On ready: pc_reg ← pend_target, state ← RUN.
  - A branch during DRAIN overwrites pend_target.
  - Out stays bubble; freeze is ignored.
- Reset: pc_reg = 0, state = RUN, out = {F000_0000, 0, 0}, skid_valid = 0, pend_target = 0, imem_req = 1 (first cycle after reset fetches address 0).

## Timing
- Zero-wait memory: one instruction per cycle; a word fetched at cycle n appears on `instruction` at n+1.
- N wait states add N bubbles per instruction.
- Branch at cycle n, no pending request: bubble at n+1; target requested at n+1; target instruction visible at n+2 (zero-wait).
- Branch during a pending request with k remaining wait cycles: target requested k+1 cycles later.
- Skid full: imem_req low until freeze drops. Skid contents move to out on the first !freeze edge; the next fetch request issues in that same cycle.
- Freeze and branch in the same cycle: flush wins.
- Reset asserted mid-request: the request is abandoned immediately. The memory model must tolerate a request being dropped by reset.

## Test plan
- Reset, then zero-wait memory with rdata = addr: instruction = 0,4,8 on successive cycles, pc = 4,8,12, valid = 1 from the 2nd cycle.
- 2 wait states per fetch: each instruction is followed by 2 bubbles (F000_0000, valid 0); imem_addr is stable during waits.
- freeze held 3 cycles while a word arrives: out holds; skid captures the word; imem_req is low after capture. On release, the skid word appears; no instruction is lost or duplicated.
- branch_taken (addr 0x100) with no wait states: next cycle valid = 0; following cycle instruction from 0x100, pc = 0x104.
- branch_taken (addr 0x203, forced to 0x200) during a 3-cycle wait: the old request is held and its data discarded, then 0x200 is fetched. A second branch to 0x300 mid-DRAIN makes 0x300 win.
- Branch with freeze high and skid full: out = bubble, skid cleared, fetch at target; PC wrap from FFFF_FFFC to 0.
